// File: rtl/fft_pkg.sv
// Shared helpers for the FFT output reorder stage: counter sizing, index
// bit reversal and the read-side state encoding.
package fft_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Width of a counter that walks one N-point frame.
  function automatic int frame_cnt_w(input int n);
    return clog2(n);
  endfunction

  // Reverse the low nbits of value; bits above nbits come back zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int nbits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) r[i] = value[(nbits - 1 - i) & 31];
    end
    return r;
  endfunction

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

endpackage

// File: rtl/fft_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, one clock.
// Contents are never reset.
module fft_dpram #(
  parameter int AW = 6,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT output frames into natural order through a
// ping-pong buffer; one frame is written while the previous one is read.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int N     = 32,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_in,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  output logic                    enable_out,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im
);

  localparam int CNT_W = frame_cnt_w(N);
  localparam int AW    = CNT_W + 1;
  localparam int DW    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic [CNT_W-1:0] wcnt;
  logic             wbank;
  logic [CNT_W-1:0] wcnt_rev;
  logic [AW-1:0]    waddr;
  logic             wr_last;

  rd_state_e        state, state_nxt;
  logic [CNT_W-1:0] rcnt, rcnt_nxt;
  logic             rbank, rbank_nxt;
  logic             rd_en_p0;
  logic [AW-1:0]    raddr_p0;

  logic [DW-1:0]    rdata_p1;
  logic             vld_p1;

  // ---- write side: samples land at their natural-order address
  assign wcnt_rev = CNT_W'(bitrev(32'(wcnt), CNT_W));
  assign waddr    = {wbank, wcnt_rev};
  assign wr_last  = enable_in && (wcnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt  <= '0;
      wbank <= 1'b0;
    end else if (enable_in) begin
      wcnt <= wcnt + 1'b1;
      if (wcnt == LAST) wbank <= ~wbank;
    end
  end

  // ---- read FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RD_IDLE;
      rcnt  <= '0;
      rbank <= 1'b0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
      rbank <= rbank_nxt;
    end
  end

  // A completing write frame starts (or chains) a readout of the bank it filled.
  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    rbank_nxt = rbank;
    case (state)
      RD_IDLE: begin
        if (wr_last) begin
          state_nxt = RD_READ;
          rcnt_nxt  = '0;
          rbank_nxt = wbank;
        end
      end
      RD_READ: begin
        if (rcnt == LAST) begin
          rcnt_nxt = '0;
          if (wr_last) begin
            rbank_nxt = wbank;
          end else begin
            state_nxt = RD_IDLE;
          end
        end else begin
          rcnt_nxt = rcnt + 1'b1;
        end
      end
      default: begin
        state_nxt = RD_IDLE;
        rcnt_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    rd_en_p0 = (state == RD_READ);
    raddr_p0 = {rbank, rcnt};
  end

  fft_dpram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk   (clk),
    .we    (enable_in),
    .waddr (waddr),
    .wdata ({in_re, in_im}),
    .re    (rd_en_p0),
    .raddr (raddr_p0),
    .rdata (rdata_p1)
  );

  // ---- stage p1: RAM data valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= rd_en_p0;
  end

  // ---- output register: data forced to zero outside valid cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_out <= 1'b0;
      out_re     <= '0;
      out_im     <= '0;
    end else begin
      enable_out <= vld_p1;
      out_re     <= vld_p1 ? $signed(rdata_p1[DW-1:WIDTH]) : '0;
      out_im     <= vld_p1 ? $signed(rdata_p1[WIDTH-1:0])  : '0;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: frame-level reference model plus directed
// latency, contiguity, extreme-value and reset sequences.
module tb_fft_bitrev_reorder;

  localparam int N = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              enable_in = 1'b0;
  logic signed [7:0] in_re = '0;
  logic signed [7:0] in_im = '0;
  logic              enable_out;
  logic signed [7:0] out_re;
  logic signed [7:0] out_im;

  always #5 clk = ~clk;

  fft_bitrev_reorder #(.N(N), .WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_in  (enable_in),
    .in_re      (in_re),
    .in_im      (in_im),
    .enable_out (enable_out),
    .out_re     (out_re),
    .out_im     (out_im)
  );

  typedef struct {
    logic signed [7:0] re;
    logic signed [7:0] im;
  } smp_t;

  typedef struct {
    logic signed [7:0] re;
    logic signed [7:0] im;
    int                slot;
    logic signed [7:0] exp_re;
    logic signed [7:0] exp_im;
  } vec_t;

  int n_err = 0;
  int n_chk = 0;

  smp_t              exp_q[$];
  logic signed [7:0] got_re[$];
  logic signed [7:0] got_im[$];
  smp_t              mbuf[N];
  int                mcnt = 0;
  int                cyc_n = 0;
  int                e_neg = 0;
  int                v_first = -1;
  int                v_last = -1;
  int                v_count = 0;
  vec_t              tbl[N];

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int rev5(input int k0);
    int k;
    int r;
    k = k0;
    r = 0;
    for (int i = 0; i < 5; i++) begin
      r = r * 2 + (k % 2);
      k = k / 2;
    end
    return r;
  endfunction

  // Reference: a full frame of N samples taken in arrival order k is emitted
  // as natural index j, where arrival k = bitreverse(j).
  task automatic model_push(input logic signed [7:0] re, input logic signed [7:0] im);
    mbuf[mcnt].re = re;
    mbuf[mcnt].im = im;
    mcnt++;
    if (mcnt == N) begin
      for (int j = 0; j < N; j++) exp_q.push_back(mbuf[rev5(j)]);
      mcnt = 0;
    end
  endtask

  task automatic model_reset();
    mcnt = 0;
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    smp_t e;
    cyc_n++;
    if (enable_out) begin
      if (v_count == 0) v_first = cyc_n;
      v_last = cyc_n;
      v_count++;
      got_re.push_back(out_re);
      got_im.push_back(out_im);
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_re", int'(out_re), int'(e.re));
        chk("out_im", int'(out_im), int'(e.im));
      end
    end else begin
      chk("idle_zero_re", int'(out_re), 0);
      chk("idle_zero_im", int'(out_im), 0);
    end
  end

  task automatic send(input logic en, input logic signed [7:0] re, input logic signed [7:0] im);
    enable_in = en;
    in_re     = re;
    in_im     = im;
    @(posedge clk);
    if (en && rst_n) begin
      model_push(re, im);
      e_neg = cyc_n;
    end
    #1;
  endtask

  task automatic clear_stats();
    v_first = -1;
    v_last  = -1;
    v_count = 0;
    got_re.delete();
    got_im.delete();
  endtask

  task automatic wait_out(input string name, input int n);
    int b;
    enable_in = 1'b0;
    b = 0;
    while (v_count < n && b < 400) begin
      @(negedge clk);
      #1;
      b++;
    end
    repeat (4) begin
      @(negedge clk);
      #1;
    end
    chk({name, "_count"}, v_count, n);
  endtask

  task automatic send_random_frame();
    for (int k = 0; k < N; k++) send(1'b1, 8'($urandom), 8'($urandom));
  endtask

  initial begin
    int lat_e;
    int b;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_enable_out", int'(enable_out), 0);
    chk("rst_out_re", int'(out_re), 0);
    chk("rst_out_im", int'(out_im), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // One frame with re = bitrev(k), im = -bitrev(k)
    clear_stats();
    for (int k = 0; k < N; k++) send(1'b1, 8'(rev5(k)), 8'(-rev5(k)));
    lat_e = e_neg;
    wait_out("s1", N);
    chk("s1_latency", v_first - lat_e, 3);
    chk("s1_contig", v_last - v_first + 1, N);
    for (int j = 0; j < N && j < got_re.size(); j++) begin
      chk("s1_re", int'(got_re[j]), j);
      chk("s1_im", int'(got_im[j]), -j);
    end

    // Three back-to-back frames, frame f offset by 32*f
    clear_stats();
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < N; k++) send(1'b1, 8'(32 * f + rev5(k)), 8'($urandom));
    wait_out("s2", 3 * N);
    chk("s2_contig", v_last - v_first + 1, 3 * N);
    for (int j = 0; j < 3 * N && j < got_re.size(); j++) chk("s2_re", int'(got_re[j]), j);

    // Same frame as the first, delivered with a stall every other cycle
    clear_stats();
    for (int k = 0; k < N; k++) begin
      send(1'b1, 8'(rev5(k)), 8'(-rev5(k)));
      send(1'b0, 8'($urandom), 8'($urandom));
    end
    wait_out("s3", N);
    chk("s3_latency", v_first - e_neg, 3);
    chk("s3_contig", v_last - v_first + 1, N);
    for (int j = 0; j < N && j < got_re.size(); j++) chk("s3_re", int'(got_re[j]), j);

    // Extremes, table-driven: every position (-128,127) except X[5]=(127,-128)
    for (int k = 0; k < N; k++) begin
      tbl[k].slot   = rev5(k);
      tbl[k].re     = (tbl[k].slot == 5) ? 8'sh7f : 8'sh80;
      tbl[k].im     = (tbl[k].slot == 5) ? 8'sh80 : 8'sh7f;
      tbl[k].exp_re = tbl[k].re;
      tbl[k].exp_im = tbl[k].im;
    end
    clear_stats();
    for (int k = 0; k < N; k++) send(1'b1, tbl[k].re, tbl[k].im);
    wait_out("s4", N);
    if (got_re.size() == N) begin
      for (int k = 0; k < N; k++) begin
        chk("s4_re", int'(got_re[tbl[k].slot]), int'(tbl[k].exp_re));
        chk("s4_im", int'(got_im[tbl[k].slot]), int'(tbl[k].exp_im));
      end
      chk("s4_x5_sixth_re", int'(got_re[5]), 127);
    end

    // Reset during readout: enable_out must drop without waiting for a clock
    clear_stats();
    send_random_frame();
    enable_in = 1'b0;
    b = 0;
    while (!enable_out && b < 20) begin
      @(negedge clk);
      #1;
      b++;
    end
    chk("s5_readout_started", int'(enable_out), 1);
    repeat (5) @(negedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("s5_async_drop", int'(enable_out), 0);
    chk("s5_async_zero_re", int'(out_re), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset after 20 samples of frame A, then a full frame B
    clear_stats();
    for (int k = 0; k < 20; k++) send(1'b1, 8'($urandom), 8'($urandom));
    enable_in = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_random_frame();
    wait_out("s5b", N);
    chk("s5b_contig", v_last - v_first + 1, N);

    // Frame B completes exactly as frame A's readout reaches its last address
    clear_stats();
    send_random_frame();
    send_random_frame();
    wait_out("s6", 2 * N);
    chk("s6_contig", v_last - v_first + 1, 2 * N);

    // Random data with random stalls
    clear_stats();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < N; k++) begin
        while ($urandom_range(0, 3) == 0) send(1'b0, 8'($urandom), 8'($urandom));
        send(1'b1, 8'($urandom), 8'($urandom));
      end
    end
    wait_out("s7", 3 * N);

    chk("model_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
